// File: rtl/reg2wb_bridge.sv
// Register-request to Wishbone classic master bridge: one Wishbone cycle per held request.
// Optional bus timeout is compiled in with `define REG2WB_TIMEOUT_EN (TO_CYCLES BUSY cycles).
module reg2wb_bridge #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 256
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [AW-1:0]     reg_addr,
  input  logic [DW/8-1:0]   reg_be,
  input  logic [DW-1:0]     reg_wdata,
  output logic [DW-1:0]     reg_rdata,
  output logic              reg_ack,
  output logic              reg_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic              wbm_we_o,
  output logic [DW-1:0]     wbm_dat_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic [1:0]        dbg_state
);

  // Handshake: reg_wr/reg_rd are levels held by the requester until reg_ack;
  // the bridge then parks in DONE until both drop, so a held request is never re-issued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   req;
  logic   timeout;
  logic   term;
  logic   term_err;

  assign req       = reg_wr | reg_rd;
  assign dbg_state = state_q;

`ifdef REG2WB_TIMEOUT_EN
  localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [CW-1:0] to_cnt;

  // to_cnt holds the number of BUSY cycles already elapsed before this one.
  assign timeout = (to_cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge mclk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state_q == IDLE && req) begin
      to_cnt <= '0;
    end else if (state_q == BUSY && !term) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  // Constant false for any legal TO_CYCLES: BUSY waits for the slave forever.
  assign timeout = (TO_CYCLES == 0);
`endif

  // A slave ack/err in the final count cycle wins over the timeout.
  assign term     = wbm_ack_i | wbm_err_i | timeout;
  assign term_err = wbm_err_i | (timeout & ~wbm_ack_i);

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req)  state_d = BUSY;
      BUSY:    if (term) state_d = DONE;
      DONE:    if (!req) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      reg_ack   <= 1'b0;
      reg_err   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack <= 1'b0;
      reg_err <= 1'b0;
      if (state_q == IDLE && req) begin
        wbm_adr_o <= reg_addr;
        wbm_sel_o <= reg_be;
        wbm_dat_o <= reg_wdata;
        wbm_we_o  <= reg_wr;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
      end
      if (state_q == BUSY && term) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        reg_ack   <= 1'b1;
        reg_err   <= term_err;
        if (term_err) begin
          reg_rdata <= '1;
        end else if (!wbm_we_o) begin
          reg_rdata <= wbm_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg2wb_bridge.sv
// Bench for reg2wb_bridge: table of register transactions against a scripted Wishbone slave,
// plus hand sequences for timeout / indefinite wait and reset during BUSY.
module tb_reg2wb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          reg_wr, reg_rd;
  logic [AW-1:0] reg_addr;
  logic [BW-1:0] reg_be;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          reg_ack, reg_err;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [BW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i, wbm_err_i;
  logic [1:0]    dbg_state;

  reg2wb_bridge #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .mclk(clk), .reset(reset),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_be(reg_be),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    int            dly;
    logic          sack;
    logic          serr;
    logic [DW-1:0] sdata;
    int            hold;
  } vec_t;

  vec_t          vecs[7];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_rdata;
  int            n_vec;
  int            n_bad;

  // scoreboard
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic [DW-1:0] rd);
    exp_q.push_back({err, rd});
    model_rdata = rd;
  endtask

  task automatic pop_check(input string tag);
    logic [DW:0] e;
    check({tag, "_ack"}, reg_ack, 1);
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_queue: reg_ack with no expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_err"}, reg_err, e[DW]);
      check({tag, "_rdata"}, reg_rdata, e[DW-1:0]);
    end
  endtask

  // driver tasks
  task automatic check_bus(input vec_t v);
    check("cyc", wbm_cyc_o, 1);
    check("stb", wbm_stb_o, 1);
    check("we", wbm_we_o, v.wr);
    check("adr", wbm_adr_o, v.addr);
    check("sel", wbm_sel_o, v.be);
    if (v.wr) check("dat_o", wbm_dat_o, v.wdata);
  endtask

  task automatic wait_stb(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      wbm_dat_i = $urandom;
    end while (!wbm_stb_o && lat < 20);
  endtask

  task automatic release_req();
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, 2'd0);
    check("idle_ack", reg_ack, 0);
    check("idle_cyc", wbm_cyc_o, 0);
    check("idle_rdata", reg_rdata, model_rdata);
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    logic [DW-1:0] exp_rd;
    exp_rd = v.serr ? {DW{1'b1}} : (v.wr ? model_rdata : v.sdata);
    @(negedge clk);
    reg_wr = v.wr; reg_rd = v.rd; reg_addr = v.addr; reg_be = v.be; reg_wdata = v.wdata;
    push_exp(v.serr, exp_rd);
    wait_stb(lat);
    if (!wbm_stb_o) begin
      n_bad++;
      $display("FAIL stb_timeout: no strobe after %0d cycles", lat);
      void'(exp_q.pop_back());
      release_req();
      return;
    end
    check("stb_latency", lat, 1);
    check_bus(v);
    for (int i = 0; i < v.dly; i++) begin
      @(negedge clk);
      lat++;
      wbm_dat_i = $urandom;
      check_bus(v);
    end
    wbm_ack_i = v.sack;
    wbm_err_i = v.serr;
    wbm_dat_i = v.sdata;
    @(negedge clk);
    lat++;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = $urandom;
    pop_check("txn");
    check("ack_latency", lat, v.dly + 2);
    check("cyc_drop", wbm_cyc_o, 0);
    check("stb_drop", wbm_stb_o, 0);
    for (int i = 0; i < v.hold; i++) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      wbm_err_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_ack", reg_ack, 0);
      check("hold_cyc", wbm_cyc_o, 0);
      check("hold_state", dbg_state, 2'd2);
      check("hold_rdata", reg_rdata, model_rdata);
    end
    release_req();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_rdata = '0;
    reset = 1'b1;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_be = '0; reg_wdata = '0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

    //                wr    rd    addr           be    wdata          dly sack  serr  sdata          hold
    vecs[0] = '{1'b1, 1'b0, 32'h3000_0010, 4'hF, 32'hA5A5_1234, 3, 1'b1, 1'b0, 32'h0000_0000, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h3000_0020, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'hCAFE_F00D, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h3000_0024, 4'hF, 32'h0000_0000, 1, 1'b1, 1'b0, 32'h1234_5678, 4};
    vecs[3] = '{1'b0, 1'b1, 32'h3000_0028, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b1, 32'h5555_AAAA, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h3000_0030, 4'h3, 32'h0BAD_BEEF, 2, 1'b1, 1'b0, 32'h7777_7777, 1};
    vecs[5] = '{1'b1, 1'b0, 32'h3000_0034, 4'hC, 32'h1111_2222, 2, 1'b0, 1'b1, 32'h0000_0000, 0};
    vecs[6] = '{1'b0, 1'b1, 32'h3000_0038, 4'h1, 32'h0000_0000, 5, 1'b1, 1'b0, 32'h0000_00A5, 2};

    repeat (3) @(negedge clk);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat_o", wbm_dat_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_ack", reg_ack, 0);
    check("rst_err", reg_err, 0);
    check("rst_rdata", reg_rdata, 0);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v.wr    = 1'($urandom_range(0, 1));
      v.rd    = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.addr  = $urandom;
      v.be    = 4'($urandom_range(0, 15));
      v.wdata = $urandom;
      v.dly   = $urandom_range(0, 4);
      v.serr  = ($urandom_range(0, 3) == 0);
      v.sack  = v.serr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.sdata = $urandom;
      v.hold  = $urandom_range(0, 3);
      run_vec(v);
    end

    // silent slave: timeout when compiled in, otherwise an indefinite wait
    begin
      int lat;
      int busy;
      @(negedge clk);
      reg_rd = 1'b1; reg_addr = 32'h3000_0040; reg_be = 4'hF;
`ifdef REG2WB_TIMEOUT_EN
      push_exp(1'b1, {DW{1'b1}});
      wait_stb(lat);
      check("to_stb_latency", lat, 1);
      busy = 1;
      for (int i = 0; i < 200 && wbm_cyc_o; i++) begin
        @(negedge clk);
        if (wbm_cyc_o) busy++;
      end
      check("to_busy_cycles", busy, TO);
      pop_check("timeout");
`else
      wait_stb(lat);
      check("wait_stb_latency", lat, 1);
      busy = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (wbm_cyc_o && wbm_stb_o && !reg_ack) busy++;
      end
      check("wait_cyc_held", busy, 1000);
      push_exp(1'b0, 32'h600D_F00D);
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h600D_F00D;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      pop_check("late_ack");
`endif
      release_req();
    end

    // reset in BUSY aborts the cycle with no reg_ack
    begin
      int lat;
      @(negedge clk);
      reg_rd = 1'b1; reg_addr = 32'h3000_0050; reg_be = 4'hF;
      wait_stb(lat);
      check("abort_stb", wbm_stb_o, 1);
      reset = 1'b1;
      reg_rd = 1'b0;
      @(negedge clk);
      model_rdata = '0;
      check("abort_cyc", wbm_cyc_o, 0);
      check("abort_stb_low", wbm_stb_o, 0);
      check("abort_ack", reg_ack, 0);
      check("abort_state", dbg_state, 2'd0);
      check("abort_adr", wbm_adr_o, 0);
      check("abort_rdata", reg_rdata, 0);
      reset = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("abort_no_ack", reg_ack, 0);
      end
      check("abort_queue", exp_q.size(), 0);
      run_vec(vecs[1]);
      run_vec(vecs[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
